mem_access_ctrl: RTL and testbench

Pipeline-side master for the word-only data memory. It sits between the MEM stage and the data memory, and it executes MIPS loads and stores (LW/LH/LHU/LB/LBU/SW/SH/SB) over the memory's 32-bit word port. Sub-word stores are turned into a read-modify-write sequence. Loads are returned lane-selected and extended. The block holds the pipeline through its `Stall` output until each access completes.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_lane_unit.sv | 55 +++++
 rtl/mem_access_ctrl.sv | 115 +++++++++++
 tb/tb_mem_access_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller: load/store
// opcodes, controller states and the alignment rule.
package mem_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } ctrlState_e;

    // Words need both low address bits clear, halves need bit 0 clear.
    function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] addrLo);
        case (op)
            OP_LW, OP_SW:         return addrLo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return addrLo[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic isLoad(input logic [2:0] op);
        return op <= OP_LBU;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane logic: selects and extends the load lane from a read
// word, and merges sub-word store data into a read word.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addrLo,
    input  logic [31:0] readWord,
    input  logic [31:0] storeData,
    output logic [31:0] loadValue,
    output logic [31:0] mergedWord
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        laneByte = 8'h00;
        case (addrLo)
            2'd0:    laneByte = readWord[7:0];
            2'd1:    laneByte = readWord[15:8];
            2'd2:    laneByte = readWord[23:16];
            default: laneByte = readWord[31:24];
        endcase
        laneHalf = addrLo[1] ? readWord[31:16] : readWord[15:0];

        loadValue = readWord;
        case (op)
            OP_LH:   loadValue = {{16{laneHalf[15]}}, laneHalf};
            OP_LHU:  loadValue = {16'h0000, laneHalf};
            OP_LB:   loadValue = {{24{laneByte[7]}}, laneByte};
            OP_LBU:  loadValue = {24'h000000, laneByte};
            default: loadValue = readWord;
        endcase

        // Untouched lanes keep the value just read from memory.
        mergedWord = readWord;
        case (op)
            OP_SB: begin
                case (addrLo)
                    2'd0:    mergedWord[7:0]   = storeData[7:0];
                    2'd1:    mergedWord[15:8]  = storeData[7:0];
                    2'd2:    mergedWord[23:16] = storeData[7:0];
                    default: mergedWord[31:24] = storeData[7:0];
                endcase
            end
            OP_SH: begin
                if (addrLo[1]) mergedWord[31:16] = storeData[15:0];
                else           mergedWord[15:0]  = storeData[15:0];
            end
            default: mergedWord = storeData;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage master for the word-only data memory: single-cycle loads, direct
// word stores and read-modify-write sub-word stores, holding the pipeline via Stall.
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic [2:0]  MemOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Done,
    output logic        AddrErr,
    output logic        Stall,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemWrEn,
    input  logic [31:0] MemRData,
    output logic [1:0]  StateDbg
);

    // Handshake: Req is held until the one-cycle Done pulse; Stall = Req && !Done.
    // Req is only sampled in IDLE, so a new access starts one cycle after Done.

    ctrlState_e  state;
    logic [2:0]  opReg;
    logic [1:0]  addrLoReg;
    logic [31:0] wDataReg;
    logic [31:0] memAddrReg;

    logic        sampling;
    logic [2:0]  laneOp;
    logic [1:0]  laneAddrLo;
    logic [31:0] laneStoreData;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;

    // The sampling cycle presents the new address directly so a load can
    // capture its data on the same edge that accepts the request.
    assign sampling      = (state == ST_IDLE) && Req;
    assign laneOp        = sampling ? MemOp      : opReg;
    assign laneAddrLo    = sampling ? Addr[1:0]  : addrLoReg;
    assign laneStoreData = sampling ? WData      : wDataReg;
    assign MemAddr       = sampling ? {Addr[31:2], 2'b00} : memAddrReg;
    assign Stall         = Req && !Done;
    assign StateDbg      = state;

    mem_lane_unit laneUnit (
        .op        (laneOp),
        .addrLo    (laneAddrLo),
        .readWord  (MemRData),
        .storeData (laneStoreData),
        .loadValue (loadValue),
        .mergedWord(mergedWord)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            opReg      <= OP_LW;
            addrLoReg  <= 2'b00;
            wDataReg   <= 32'h0;
            memAddrReg <= 32'h0;
            MemWData   <= 32'h0;
            MemWrEn    <= 1'b0;
            RData      <= 32'h0;
            Done       <= 1'b0;
            AddrErr    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Req) begin
                        opReg      <= MemOp;
                        addrLoReg  <= Addr[1:0];
                        wDataReg   <= WData;
                        memAddrReg <= {Addr[31:2], 2'b00};
                        if (isMisaligned(MemOp, Addr[1:0])) begin
                            AddrErr <= 1'b1;
                            Done    <= 1'b1;
                            state   <= ST_RESP;
                        end else if (isLoad(MemOp)) begin
                            RData <= loadValue;
                            Done  <= 1'b1;
                            state <= ST_RESP;
                        end else if (MemOp == OP_SW) begin
                            MemWData <= WData;
                            MemWrEn  <= 1'b1;
                            state    <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    MemWData <= mergedWord;
                    MemWrEn  <= 1'b1;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    MemWrEn <= 1'b0;
                    Done    <= 1'b1;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    Done    <= 1'b0;
                    AddrErr <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, held-Req and reset corner
// sequences, then random accesses against a byte-array memory model.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Req = 1'b0;
    logic [2:0]  MemOp = 3'd0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WData = 32'h0;
    logic [31:0] RData;
    logic        Done;
    logic        AddrErr;
    logic        Stall;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemWrEn;
    logic [31:0] MemRData;
    logic [1:0]  StateDbg;

    mem_access_ctrl dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .MemOp   (MemOp),
        .Addr    (Addr),
        .WData   (WData),
        .RData   (RData),
        .Done    (Done),
        .AddrErr (AddrErr),
        .Stall   (Stall),
        .MemAddr (MemAddr),
        .MemWData(MemWData),
        .MemWrEn (MemWrEn),
        .MemRData(MemRData),
        .StateDbg(StateDbg)
    );

    // ---------------- clock / reset / memory ----------------
    always #5 Clk = ~Clk;

    logic [31:0] mem [0:63];
    logic        pokeEn = 1'b0;
    logic [5:0]  pokeIdx = 6'd0;
    logic [31:0] pokeVal = 32'h0;

    assign MemRData = mem[MemAddr[7:2]];

    always @(posedge Clk) begin
        if (pokeEn)       mem[pokeIdx] <= pokeVal;
        else if (MemWrEn) mem[MemAddr[7:2]] <= MemWData;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    logic [7:0]  refMem [0:255];
    logic [31:0] lastRData = 32'h0;

    function automatic logic [31:0] refWord(input int idx);
        return {refMem[4*idx+3], refMem[4*idx+2], refMem[4*idx+1], refMem[4*idx]};
    endfunction

    task automatic modelAccess(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                               output int lat, output logic err, output logic [31:0] rd, output int wr);
        int size;
        int base;
        logic isLd;
        logic [31:0] v;
        case (op)
            OP_LW, OP_SW:         size = 4;
            OP_LH, OP_LHU, OP_SH: size = 2;
            default:              size = 1;
        endcase
        isLd = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LB) || (op == OP_LBU);
        base = int'(addr[7:0]);
        err  = (base % size) != 0;
        wr   = 0;
        if (err) begin
            lat = 1;
        end else if (isLd) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(refMem[base + i]) << (8 * i));
            if (op == OP_LB && v[7])  v = v | 32'hFFFF_FF00;
            if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
            lastRData = v;
            lat = 1;
        end else begin
            for (int i = 0; i < size; i++) refMem[base + i] = 8'(wd >> (8 * i));
            lat = (size == 4) ? 2 : 3;
            wr  = 1;
        end
        rd = lastRData;
    endtask

    // ---------------- drivers ----------------
    bit inResp = 1'b0;

    task automatic poke(input int idx, input logic [31:0] val);
        pokeEn  = 1'b1;
        pokeIdx = 6'(idx);
        pokeVal = val;
        for (int i = 0; i < 4; i++) refMem[4*idx + i] = 8'(val >> (8 * i));
        @(posedge Clk);
        #1;
        pokeEn = 1'b0;
    endtask

    // One access; when keepReq is set, Req stays high into the next call.
    task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int expLat, input logic expErr, input logic [31:0] expRData,
                          input int expWr, input bit keepReq);
        int cyc = 0;
        int stallCnt = 0;
        int wrCnt = 0;
        bit gotDone = 1'b0;
        int lat;
        lat   = expLat + (inResp ? 1 : 0);
        MemOp = op;
        Addr  = addr;
        WData = wd;
        Req   = 1'b1;
        exp_q.push_back(expRData);
        #1;
        if (Stall) stallCnt++;
        while (!gotDone && cyc < 8) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (MemWrEn) wrCnt++;
            if (Stall) stallCnt++;
            if (Done) gotDone = 1'b1;
        end
        checkBit("done_seen", gotDone, 1'b1);
        check("latency", 32'(cyc), 32'(lat));
        checkBit("addr_err", AddrErr, expErr);
        check("rdata", RData, exp_q.pop_front());
        check("wr_cycles", 32'(wrCnt), 32'(expWr));
        check("stall_cycles", 32'(stallCnt), 32'(expLat));
        if (keepReq) begin
            inResp = 1'b1;
        end else begin
            Req    = 1'b0;
            inResp = 1'b0;
            @(posedge Clk);
            #1;
            checkBit("done_pulse", Done, 1'b0);
            checkBit("err_cleared", AddrErr, 1'b0);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRData;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int mLat;
        int mWr;
        logic mErr;
        logic [31:0] mRd;
        int expWr;
        int waitCyc;
        int doneCnt;
        logic [2:0] rOp;
        logic [31:0] rAddr;
        logic [31:0] rWd;

        vecs[0]  = '{OP_LB,  32'h10, 32'h0,         32'hFFFF_FFF4, 1'b0, 1};
        vecs[1]  = '{OP_LBU, 32'h10, 32'h0,         32'h0000_00F4, 1'b0, 1};
        vecs[2]  = '{OP_LH,  32'h12, 32'h0,         32'hFFFF_8822, 1'b0, 1};
        vecs[3]  = '{OP_LHU, 32'h12, 32'h0,         32'h0000_8822, 1'b0, 1};
        vecs[4]  = '{OP_SB,  32'h11, 32'h0000_00AB, 32'h0000_8822, 1'b0, 3};
        vecs[5]  = '{OP_LW,  32'h10, 32'h0,         32'h8822_ABF4, 1'b0, 1};
        vecs[6]  = '{OP_SH,  32'h13, 32'h0000_1234, 32'h8822_ABF4, 1'b1, 1};
        vecs[7]  = '{OP_LW,  32'h10, 32'h0,         32'h8822_ABF4, 1'b0, 1};
        vecs[8]  = '{OP_LB,  32'h13, 32'h0,         32'hFFFF_FF88, 1'b0, 1};
        vecs[9]  = '{OP_LH,  32'h10, 32'h0,         32'hFFFF_ABF4, 1'b0, 1};
        vecs[10] = '{OP_LW,  32'h12, 32'h0,         32'hFFFF_ABF4, 1'b1, 1};
        vecs[11] = '{OP_SH,  32'h12, 32'h1234_5678, 32'hFFFF_ABF4, 1'b0, 3};
        vecs[12] = '{OP_LW,  32'h10, 32'h0,         32'h5678_ABF4, 1'b0, 1};
        vecs[13] = '{OP_LBU, 32'h11, 32'h0,         32'h0000_00AB, 1'b0, 1};

        // Seed memory while reset is held; word 0x10 gets the known pattern.
        for (int i = 0; i < 64; i++) poke(i, (i == 4) ? 32'h8822_33F4 : $urandom);

        check("reset_memaddr", MemAddr, 32'h0);
        check("reset_memwdata", MemWData, 32'h0);
        checkBit("reset_memwren", MemWrEn, 1'b0);
        check("reset_rdata", RData, 32'h0);
        checkBit("reset_done", Done, 1'b0);
        checkBit("reset_addrerr", AddrErr, 1'b0);
        check("reset_state", 32'(StateDbg), 32'(ST_IDLE));

        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        for (int v = 0; v < 14; v++) begin
            expWr = (vecs[v].op >= OP_SW && !vecs[v].expErr) ? 1 : 0;
            modelAccess(vecs[v].op, vecs[v].addr, vecs[v].wdata, mLat, mErr, mRd, mWr);
            access(vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].expLat, vecs[v].expErr,
                   vecs[v].expRData, expWr, 1'b0);
            if (v == 4) check("sb_word", mem[4], 32'h8822_ABF4);
            if (v == 6) check("sh_err_word", mem[4], 32'h8822_ABF4);
        end
        check("sh_word", mem[4], 32'h5678_ABF4);

        // SW then LW with Req held continuously across Done.
        modelAccess(OP_SW, 32'h14, 32'hDEAD_BEEF, mLat, mErr, mRd, mWr);
        access(OP_SW, 32'h14, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_00AB, 1, 1'b1);
        modelAccess(OP_LW, 32'h14, 32'h0, mLat, mErr, mRd, mWr);
        access(OP_LW, 32'h14, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);

        // Reset pulsed during the WRITE cycle of an SB.
        poke(4, 32'h8822_33F4);
        MemOp = OP_SB;
        Addr  = 32'h10;
        WData = 32'h0000_0055;
        Req   = 1'b1;
        waitCyc = 0;
        while (!MemWrEn && waitCyc < 6) begin
            @(posedge Clk);
            #1;
            waitCyc++;
        end
        checkBit("rst_reached_write", MemWrEn, 1'b1);
        #2;
        Reset = 1'b0;
        Req   = 1'b0;
        #1;
        checkBit("rst_memwren_async", MemWrEn, 1'b0);
        checkBit("rst_done", Done, 1'b0);
        check("rst_rdata", RData, 32'h0);
        checkBit("rst_addrerr", AddrErr, 1'b0);
        check("rst_memwdata", MemWData, 32'h0);
        check("rst_memaddr", MemAddr, 32'h0);
        check("rst_state", 32'(StateDbg), 32'(ST_IDLE));
        @(posedge Clk);
        #1;
        check("rst_word_kept", mem[4], 32'h8822_33F4);
        @(negedge Clk);
        Reset = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            if (Done) doneCnt++;
        end
        check("rst_no_done", 32'(doneCnt), 32'h0);
        check("rst_idle_after", 32'(StateDbg), 32'(ST_IDLE));
        check("rst_word_final", mem[4], 32'h8822_33F4);
        lastRData = 32'h0;
        inResp    = 1'b0;

        // Random accesses against the byte-level model.
        for (int n = 0; n < 60; n++) begin
            rOp   = 3'($urandom_range(0, 7));
            rAddr = 32'(($urandom_range(0, 63) * 4) + $urandom_range(0, 3));
            rWd   = $urandom;
            modelAccess(rOp, rAddr, rWd, mLat, mErr, mRd, mWr);
            access(rOp, rAddr, rWd, mLat, mErr, mRd, mWr, (n < 59) ? bit'($urandom_range(0, 1)) : 1'b0);
            check("rand_word", mem[rAddr[7:2]], refWord(int'(rAddr[7:2])));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
